// File: rtl/acc_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acc_alu_ctrl
// Desc     : 16-bit accumulator, six-control-bit ALU and opcode control/halt.
// Revision : 1.0 - initial release
// ============================================================================
module acc_alu_ctrl (
  input  logic        clk,
  input  logic        rst_acc,
  input  logic [4:0]  opcode,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic [15:0] alu_out,
  output logic        zr,
  output logic        ng,
  output logic        wr,
  output logic        pc_hold
);

  localparam logic [0:0] c_RUN  = 1'b0;
  localparam logic [0:0] c_HALT = 1'b1;

  localparam logic [4:0] c_LAST_ALU = 5'b10001;
  localparam logic [4:0] c_LDA      = 5'b10010;
  localparam logic [4:0] c_STA      = 5'b10011;
  localparam logic [4:0] c_HLT      = 5'b10101;
  localparam logic [4:0] c_HLTZ     = 5'b10110;
  localparam logic [4:0] c_HLTN     = 5'b10111;
  localparam logic [5:0] c_PASS_X   = 6'b001100;

  logic [0:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;

  logic [5:0]  w_ctrl;
  logic        w_alu_load;
  logic        w_lda;
  logic        w_sta;
  logic        w_halt_take;

  logic [15:0] w_x0, w_x1, w_y0, w_y1, w_f;

  // Opcode decode; while halted the opcode is ignored entirely.
  always_comb begin
    w_ctrl      = c_PASS_X;
    w_alu_load  = 1'b0;
    w_lda       = 1'b0;
    w_sta       = 1'b0;
    w_halt_take = 1'b0;
    if (state_q == c_RUN) begin
      w_alu_load = (opcode <= c_LAST_ALU);
      w_lda      = (opcode == c_LDA);
      w_sta      = (opcode == c_STA);
      unique case (opcode)
        5'b00000: w_ctrl = 6'b101010;
        5'b00001: w_ctrl = 6'b111111;
        5'b00010: w_ctrl = 6'b111010;
        5'b00011: w_ctrl = 6'b001100;
        5'b00100: w_ctrl = 6'b110000;
        5'b00101: w_ctrl = 6'b001101;
        5'b00110: w_ctrl = 6'b110001;
        5'b00111: w_ctrl = 6'b001111;
        5'b01000: w_ctrl = 6'b110011;
        5'b01001: w_ctrl = 6'b011111;
        5'b01010: w_ctrl = 6'b110111;
        5'b01011: w_ctrl = 6'b001110;
        5'b01100: w_ctrl = 6'b110010;
        5'b01101: w_ctrl = 6'b000010;
        5'b01110: w_ctrl = 6'b010011;
        5'b01111: w_ctrl = 6'b000111;
        5'b10000: w_ctrl = 6'b000000;
        5'b10001: w_ctrl = 6'b010101;
        default:  w_ctrl = c_PASS_X;
      endcase
      w_halt_take = (opcode == c_HLT) ||
                    ((opcode == c_HLTZ) && (acc_q == 16'h0000)) ||
                    ((opcode == c_HLTN) && acc_q[15]);
    end
  end

  // ALU: control bits ordered zx nx zy ny f no.
  always_comb begin
    w_x0    = w_ctrl[5] ? 16'h0000 : acc_q;
    w_x1    = w_ctrl[4] ? ~w_x0 : w_x0;
    w_y0    = w_ctrl[3] ? 16'h0000 : data_in;
    w_y1    = w_ctrl[2] ? ~w_y0 : w_y0;
    w_f     = w_ctrl[1] ? (w_x1 + w_y1) : (w_x1 & w_y1);
    alu_out = w_ctrl[0] ? ~w_f : w_f;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_acc) begin
      state_q <= c_RUN;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (state_q == c_RUN) begin
      if (w_halt_take) begin
        state_d = c_HALT;
      end
      if (w_lda) begin
        acc_d = data_in;
      end else if (w_alu_load) begin
        acc_d = alu_out;
      end
    end
  end

  // Output logic
  always_comb begin
    data_out = acc_q;
    zr       = (alu_out == 16'h0000);
    ng       = alu_out[15];
    wr       = w_sta;
    pc_hold  = (state_q == c_HALT) || w_halt_take;
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_alu_ctrl
// Desc     : Directed self-checking bench for acc_alu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_alu_ctrl;

  logic        clk;
  logic        rst_acc;
  logic [4:0]  opcode;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] alu_out;
  logic        zr;
  logic        ng;
  logic        wr;
  logic        pc_hold;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] OP_XP1 = 5'b01001;
  localparam logic [4:0] OP_LDA = 5'b10010;
  localparam logic [4:0] OP_STA = 5'b10011;
  localparam logic [4:0] OP_NOP = 5'b10100;
  localparam logic [4:0] OP_HLT = 5'b10101;
  localparam logic [4:0] OP_HLZ = 5'b10110;
  localparam logic [4:0] OP_HLN = 5'b10111;

  acc_alu_ctrl dut (
    .clk      (clk),
    .rst_acc  (rst_acc),
    .opcode   (opcode),
    .data_in  (data_in),
    .data_out (data_out),
    .alu_out  (alu_out),
    .zr       (zr),
    .ng       (ng),
    .wr       (wr),
    .pc_hold  (pc_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [15:0] din);
    opcode  = op;
    data_in = din;
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    drive(OP_LDA, v);
    tick();
  endtask

  task automatic test_reset();
    rst_acc = 1'b1;
    drive(OP_NOP, 16'h0000);
    tick();
    rst_acc = 1'b0;
    checks++;
    if (data_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data_out: got %h expected 0000", data_out);
    end
    checks++;
    if (pc_hold !== 1'b0 || wr !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got pc_hold=%b wr=%b expected 0 0", pc_hold, wr);
    end
    load(16'h1234);
    checks++;
    if (data_out !== 16'h1234) begin
      failures++;
      $display("FAIL reset_lda: got %h expected 1234", data_out);
    end
  endtask

  task automatic test_alu_sweep();
    logic [15:0] exp_v [18];
    exp_v[0]  = 16'h0000; exp_v[1]  = 16'h0001; exp_v[2]  = 16'hFFFF;
    exp_v[3]  = 16'h00F0; exp_v[4]  = 16'h0F0F; exp_v[5]  = 16'hFF0F;
    exp_v[6]  = 16'hF0F0; exp_v[7]  = 16'hFF10; exp_v[8]  = 16'hF0F1;
    exp_v[9]  = 16'h00F1; exp_v[10] = 16'h0F10; exp_v[11] = 16'h00EF;
    exp_v[12] = 16'h0F0E; exp_v[13] = 16'h0FFF; exp_v[14] = 16'hF1E1;
    exp_v[15] = 16'h0E1F; exp_v[16] = 16'h0000; exp_v[17] = 16'h0FFF;
    for (int i = 0; i < 18; i++) begin
      load(16'h00F0);
      drive(5'(i), 16'h0F0F);
      checks++;
      if (alu_out !== exp_v[i] || zr !== (exp_v[i] == 16'h0000) || ng !== exp_v[i][15]) begin
        failures++;
        $display("FAIL alu_op%0d: got %h zr=%b ng=%b expected %h", i, alu_out, zr, ng, exp_v[i]);
      end
      tick();
      checks++;
      if (data_out !== exp_v[i]) begin
        failures++;
        $display("FAIL alu_acc_op%0d: got %h expected %h", i, data_out, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    load(16'hFFFF);
    drive(OP_XP1, 16'h0000);
    tick();
    drive(OP_NOP, 16'h0000);
    checks++;
    if (data_out !== 16'h0000 || zr !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ffff: got %h zr=%b expected 0000 zr=1", data_out, zr);
    end
    load(16'h7FFF);
    drive(OP_XP1, 16'h0000);
    tick();
    drive(OP_NOP, 16'h0000);
    checks++;
    if (data_out !== 16'h8000 || ng !== 1'b1) begin
      failures++;
      $display("FAIL wrap_7fff: got %h ng=%b expected 8000 ng=1", data_out, ng);
    end
  endtask

  task automatic test_sta();
    load(16'hBEEF);
    drive(OP_STA, 16'h1111);
    checks++;
    if (wr !== 1'b1 || data_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL sta_wr: got wr=%b data_out=%h expected 1 beef", wr, data_out);
    end
    tick();
    drive(OP_NOP, 16'h2222);
    checks++;
    if (wr !== 1'b0 || data_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL sta_after: got wr=%b data_out=%h expected 0 beef", wr, data_out);
    end
  endtask

  task automatic test_cond_halt();
    load(16'h0005);
    drive(OP_HLZ, 16'h0000);
    checks++;
    if (pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL hltz_nz: got pc_hold=%b expected 0", pc_hold);
    end
    tick();
    drive(OP_NOP, 16'h0000);
    checks++;
    if (pc_hold !== 1'b0 || data_out !== 16'h0005) begin
      failures++;
      $display("FAIL hltz_nz_after: got pc_hold=%b acc=%h expected 0 0005", pc_hold, data_out);
    end
    load(16'h0000);
    drive(OP_HLZ, 16'h0000);
    checks++;
    if (pc_hold !== 1'b1) begin
      failures++;
      $display("FAIL hltz_z: got pc_hold=%b expected 1", pc_hold);
    end
    tick();
    drive(OP_LDA, 16'h0001);
    checks++;
    if (pc_hold !== 1'b1 || wr !== 1'b0) begin
      failures++;
      $display("FAIL halted_lda: got pc_hold=%b wr=%b expected 1 0", pc_hold, wr);
    end
    tick();
    drive(OP_STA, 16'h0001);
    checks++;
    if (data_out !== 16'h0000 || wr !== 1'b0 || pc_hold !== 1'b1) begin
      failures++;
      $display("FAIL halted_hold: got acc=%h wr=%b pc_hold=%b expected 0000 0 1", data_out, wr, pc_hold);
    end
    rst_acc = 1'b1;
    drive(OP_NOP, 16'h0000);
    tick();
    rst_acc = 1'b0;
    #1;
    checks++;
    if (pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset: got pc_hold=%b expected 0", pc_hold);
    end
  endtask

  task automatic test_hltn_reset_priority();
    load(16'h8001);
    drive(OP_HLN, 16'h0000);
    checks++;
    if (pc_hold !== 1'b1) begin
      failures++;
      $display("FAIL hltn: got pc_hold=%b expected 1", pc_hold);
    end
    tick();
    drive(OP_NOP, 16'h0000);
    checks++;
    if (pc_hold !== 1'b1) begin
      failures++;
      $display("FAIL hltn_stay: got pc_hold=%b expected 1", pc_hold);
    end
    rst_acc = 1'b1;
    drive(OP_LDA, 16'h5555);
    tick();
    rst_acc = 1'b0;
    drive(OP_NOP, 16'h0000);
    checks++;
    if (data_out !== 16'h0000 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL rst_vs_lda: got acc=%h pc_hold=%b expected 0000 0", data_out, pc_hold);
    end
    load(16'h4321);
    rst_acc = 1'b1;
    drive(OP_HLT, 16'h0000);
    tick();
    rst_acc = 1'b0;
    drive(OP_NOP, 16'h0000);
    checks++;
    if (data_out !== 16'h0000 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL rst_vs_hlt: got acc=%h pc_hold=%b expected 0000 0", data_out, pc_hold);
    end
    drive(OP_HLN, 16'h0000);
    checks++;
    if (pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL hltn_pos: got pc_hold=%b expected 0", pc_hold);
    end
  endtask

  initial begin
    rst_acc = 1'b1;
    opcode  = OP_NOP;
    data_in = 16'h0000;
    tick();
    test_reset();
    test_alu_sweep();
    test_wrap();
    test_sta();
    test_cond_halt();
    test_hltn_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
